// File: rtl/push_conditioner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | push_conditioner_pkg : shared channel FSM encodings, button indices |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
package push_conditioner_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CONFIRM_ON  = 3'd1,
      HOLD        = 3'd2,
      REPEAT      = 3'd3,
      CONFIRM_OFF = 3'd4
   } chan_state_t;

   localparam int BAR1_RIGHT  = 0;
   localparam int BAR1_LEFT   = 1;
   localparam int BAR2_RIGHT  = 2;
   localparam int BAR2_LEFT   = 3;
   localparam int NUM_BUTTONS = 4;

endpackage
`default_nettype wire

// File: rtl/push_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | push_conditioner_if : raw buttons in, conditioned levels/pulses out |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface push_conditioner_if;
   import push_conditioner_pkg::*;

   logic [NUM_BUTTONS-1:0] PUSH;
   logic [NUM_BUTTONS-1:0] LEVEL;
   logic [NUM_BUTTONS-1:0] PRESS;
   logic                   TICK;

   modport master (output PUSH, input LEVEL, input PRESS, input TICK);
   modport slave  (input PUSH, output LEVEL, output PRESS, output TICK);

endinterface
`default_nettype wire

// File: rtl/push_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | push_channel : one button - synchroniser, tick debounce, repeat FSM |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module push_channel
   import push_conditioner_pkg::*;
#(
   parameter logic [7:0] DEBOUNCE_TICKS = 8'd4,
   parameter logic [7:0] REPEAT_DELAY   = 8'd200,
   parameter logic [7:0] REPEAT_RATE    = 8'd50
) (
   input  wire  CLK,
   input  wire  RSTn,
   input  wire  TICK,
   input  wire  PUSH,
   output logic LEVEL,
   output logic PULSE
);

   logic [1:0]  sync_ff;
   chan_state_t state;
   logic [7:0]  cnt;
   logic        from_repeat;
   logic        sync;
   logic [7:0]  cnt_inc;

   assign sync    = sync_ff[1];
   assign cnt_inc = cnt + 8'd1;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync_ff     <= 2'b00;
         state       <= IDLE;
         cnt         <= 8'd0;
         from_repeat <= 1'b0;
         LEVEL       <= 1'b0;
         PULSE       <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], PUSH};
         PULSE   <= 1'b0;
         if (TICK) begin
            case (state)
               IDLE: begin
                  if (sync) begin
                     if (DEBOUNCE_TICKS == 8'd1) begin
                        LEVEL <= 1'b1;
                        PULSE <= 1'b1;
                        state <= HOLD;
                        cnt   <= 8'd0;
                     end else begin
                        state <= CONFIRM_ON;
                        cnt   <= 8'd1;
                     end
                  end
               end
               CONFIRM_ON: begin
                  if (!sync) begin
                     state <= IDLE;
                     cnt   <= 8'd0;
                  end else if (cnt_inc == DEBOUNCE_TICKS) begin
                     LEVEL <= 1'b1;
                     PULSE <= 1'b1;
                     state <= HOLD;
                     cnt   <= 8'd0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               HOLD: begin
                  // With a single-tick debounce, release completes on the first low sample.
                  if (!sync) begin
                     from_repeat <= 1'b0;
                     if (DEBOUNCE_TICKS == 8'd1) begin
                        LEVEL <= 1'b0;
                        state <= IDLE;
                        cnt   <= 8'd0;
                     end else begin
                        state <= CONFIRM_OFF;
                        cnt   <= 8'd1;
                     end
                  end else if (REPEAT_DELAY != 8'd0) begin
                     if (cnt_inc == REPEAT_DELAY) begin
                        PULSE <= 1'b1;
                        state <= REPEAT;
                        cnt   <= 8'd0;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end
               end
               REPEAT: begin
                  if (!sync) begin
                     from_repeat <= 1'b1;
                     if (DEBOUNCE_TICKS == 8'd1) begin
                        LEVEL <= 1'b0;
                        state <= IDLE;
                        cnt   <= 8'd0;
                     end else begin
                        state <= CONFIRM_OFF;
                        cnt   <= 8'd1;
                     end
                  end else if (cnt_inc == REPEAT_RATE) begin
                     PULSE <= 1'b1;
                     cnt   <= 8'd0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               CONFIRM_OFF: begin
                  if (sync) begin
                     state <= from_repeat ? REPEAT : HOLD;
                     cnt   <= 8'd0;
                  end else if (cnt_inc == DEBOUNCE_TICKS) begin
                     LEVEL <= 1'b0;
                     state <= IDLE;
                     cnt   <= 8'd0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/push_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | push_conditioner : sample tick, four button channels, pair lockout  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module push_conditioner
   import push_conditioner_pkg::*;
#(
   parameter logic [21:0] TICK_DIV       = 22'd2000,
   parameter logic [7:0]  DEBOUNCE_TICKS = 8'd4,
   parameter logic [7:0]  REPEAT_DELAY   = 8'd200,
   parameter logic [7:0]  REPEAT_RATE    = 8'd50
) (
   input wire                CLK,
   input wire                RSTn,
   push_conditioner_if.slave bus
);

   logic [21:0]            tick_cnt;
   logic                   tick;
   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] raw_pulse;
   logic                   lock_bar1;
   logic                   lock_bar2;

   assign tick = (tick_cnt == TICK_DIV);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         tick_cnt <= 22'd0;
      end else if (tick) begin
         tick_cnt <= 22'd0;
      end else begin
         tick_cnt <= tick_cnt + 22'd1;
      end
   end

   genvar i;
   generate
      for (i = 0; i < NUM_BUTTONS; i++) begin : g_chan
         push_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
         ) u_chan (
            .CLK   (CLK),
            .RSTn  (RSTn),
            .TICK  (tick),
            .PUSH  (bus.PUSH[i]),
            .LEVEL (level[i]),
            .PULSE (raw_pulse[i])
         );
      end
   endgenerate

   // Both levels are registered alongside the pulses, so this gates on the post-update state.
   assign lock_bar1 = level[BAR1_RIGHT] & level[BAR1_LEFT];
   assign lock_bar2 = level[BAR2_RIGHT] & level[BAR2_LEFT];

   assign bus.TICK  = tick;
   assign bus.LEVEL = level;
   assign bus.PRESS = raw_pulse & ~{lock_bar2, lock_bar2, lock_bar1, lock_bar1};

endmodule
`default_nettype wire

// File: tb/tb_push_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_push_conditioner : cycle scoreboard plus directed timing checks  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_push_conditioner;
   import push_conditioner_pkg::*;

   localparam int TD = 3;
   localparam int DB = 2;
   localparam int RD = 4;
   localparam int RR = 2;
   localparam int TP = TD + 1;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   push_conditioner_if bus ();

   push_conditioner #(
      .TICK_DIV       (22'd3),
      .DEBOUNCE_TICKS (8'd2),
      .REPEAT_DELAY   (8'd4),
      .REPEAT_RATE    (8'd2)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [3:0] level;
      logic [3:0] press;
      logic       tick;
   } exp_t;

   exp_t sb[$];

   // Reference model: per channel, count consecutive disagreeing samples and ticks held.
   logic [3:0] m_s1 = '0, m_s2 = '0;
   int         m_tc = 0;
   int         m_agree[4], m_held[4];
   bit         m_lvl[4], m_rep[4];

   always @(posedge CLK) begin
      exp_t       e;
      logic [3:0] pul, lv, lk;
      bit         mtick, s;
      mtick = (m_tc == TD);
      pul   = '0;
      if (!RSTn) begin
         m_s1 = '0; m_s2 = '0; m_tc = 0;
         for (int i = 0; i < 4; i++) begin
            m_agree[i] = 0; m_held[i] = 0; m_lvl[i] = 0; m_rep[i] = 0;
         end
      end else begin
         if (mtick) begin
            for (int i = 0; i < 4; i++) begin
               s = m_s2[i];
               if (s != m_lvl[i]) begin
                  m_agree[i]++;
                  if (m_agree[i] == DB) begin
                     m_lvl[i] = s; m_agree[i] = 0;
                     if (s) begin pul[i] = 1'b1; m_held[i] = 0; m_rep[i] = 0; end
                  end
               end else if (m_agree[i] > 0) begin
                  m_agree[i] = 0; m_held[i] = 0;
               end else if (m_lvl[i] && RD != 0) begin
                  m_held[i]++;
                  if (m_held[i] == (m_rep[i] ? RR : RD)) begin
                     pul[i] = 1'b1; m_rep[i] = 1; m_held[i] = 0;
                  end
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = bus.PUSH;
         m_tc = mtick ? 0 : m_tc + 1;
      end
      for (int i = 0; i < 4; i++) lv[i] = m_lvl[i];
      lk = {{2{lv[2] & lv[3]}}, {2{lv[0] & lv[1]}}};
      e.level = lv;
      e.press = pul & ~lk;
      e.tick  = (m_tc == TD);
      sb.push_back(e);
   end

   int cyc = 0;
   int pc[4];
   int p1_times[$];

   always @(negedge CLK) begin
      exp_t e;
      cyc++;
      for (int i = 0; i < 4; i++) if (bus.PRESS[i]) pc[i]++;
      if (bus.PRESS[1]) p1_times.push_back(cyc);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_level", int'(bus.LEVEL), int'(e.level));
         check("sb_press", int'(bus.PRESS), int'(e.press));
         check("sb_tick",  int'(bus.TICK),  int'(e.tick));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic wait_press(input string tag, input int ch, input int limit, output int lat);
      lat = -1;
      for (int k = 1; k <= limit; k++) begin
         step(1);
         if (bus.PRESS[ch]) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) pc[i] = 0;
      p1_times.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      for (int i = 0; i < 4; i++) pc[i] = 0;
      bus.PUSH = 4'hF;
      RSTn     = 1'b0;

      // Reset with all buttons pressed
      for (int k = 0; k < 5; k++) begin
         step(1);
         check("rst_level", int'(bus.LEVEL), 0);
         check("rst_press", int'(bus.PRESS), 0);
         check("rst_tick",  int'(bus.TICK),  0);
      end
      bus.PUSH = 4'h0;
      RSTn     = 1'b1;
      step(1); check("first_tick_c1", int'(bus.TICK), 0);
      step(1); check("first_tick_c2", int'(bus.TICK), 0);
      step(1); check("first_tick_c3", int'(bus.TICK), 1);
      step(TP * 2);

      // Clean press on channel 0
      clear_counts();
      bus.PUSH[BAR1_RIGHT] = 1'b1;
      wait_press("clean", BAR1_RIGHT, 20, lat);
      check("clean_lat_min", int'(lat >= 7), 1);
      check("clean_lat_max", int'(lat <= 11), 1);
      check("clean_level", int'(bus.LEVEL[BAR1_RIGHT]), 1);
      step(RD * TP - 1);
      check("clean_no_early_repeat", pc[BAR1_RIGHT], 1);
      step(1);
      check("clean_first_repeat", pc[BAR1_RIGHT], 2);
      bus.PUSH[BAR1_RIGHT] = 1'b0;
      step(TP * 4);
      check("clean_release_level", int'(bus.LEVEL[BAR1_RIGHT]), 0);

      // Hold-to-repeat on channel 1
      clear_counts();
      bus.PUSH[BAR1_LEFT] = 1'b1;
      step(TP * 12);
      check("rep_count_ge4", int'(p1_times.size() >= 4), 1);
      if (p1_times.size() >= 4) begin
         check("rep_gap_delay", p1_times[1] - p1_times[0], RD * TP);
         check("rep_gap_rate1", p1_times[2] - p1_times[1], RR * TP);
         check("rep_gap_rate2", p1_times[3] - p1_times[2], RR * TP);
      end
      bus.PUSH[BAR1_LEFT] = 1'b0;
      step(TP * 3);
      check("rep_release_level", int'(bus.LEVEL[BAR1_LEFT]), 0);

      // Bounce on channel 2: toggling every 4 clocks gives alternating samples
      clear_counts();
      for (int k = 0; k < 10; k++) begin
         bus.PUSH[BAR2_RIGHT] = ~bus.PUSH[BAR2_RIGHT];
         step(4);
      end
      check("bounce_no_press", pc[BAR2_RIGHT], 0);
      check("bounce_no_level", int'(bus.LEVEL[BAR2_RIGHT]), 0);
      bus.PUSH[BAR2_RIGHT] = 1'b1;
      wait_press("bounce", BAR2_RIGHT, 20, lat);
      step(TP * 3);
      check("bounce_one_press", pc[BAR2_RIGHT], 1);

      // Lockout: add channel 3 while channel 2 is held
      bus.PUSH[BAR2_LEFT] = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         if (bus.LEVEL[BAR2_LEFT]) begin lat = k; break; end
      end
      check("lock_level3_set", int'(lat > 0), 1);
      clear_counts();
      step(TP * 10);
      check("lock_press2_blocked", pc[BAR2_RIGHT], 0);
      check("lock_press3_blocked", pc[BAR2_LEFT], 0);
      check("lock_level2_kept", int'(bus.LEVEL[BAR2_RIGHT]), 1);
      bus.PUSH[BAR2_LEFT] = 1'b0;
      step(TP * 6);
      check("lock_level3_clear", int'(bus.LEVEL[BAR2_LEFT]), 0);
      check("lock_press2_resume", int'(pc[BAR2_RIGHT] > 0), 1);
      check("lock_press3_none", pc[BAR2_LEFT], 0);
      bus.PUSH[BAR2_RIGHT] = 1'b0;
      step(TP * 4);

      // Mid-operation reset during repeat on channel 0
      bus.PUSH[BAR1_RIGHT] = 1'b1;
      step(TP * 10);
      RSTn = 1'b0;
      step(1);
      check("midrst_level", int'(bus.LEVEL), 0);
      check("midrst_press", int'(bus.PRESS), 0);
      step(2);
      clear_counts();
      RSTn = 1'b1;
      wait_press("midrst", BAR1_RIGHT, 30, lat);
      check("midrst_latency", lat, 2 * TP);
      check("midrst_single", pc[BAR1_RIGHT], 1);
      bus.PUSH = 4'h0;
      step(TP * 4);

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
